// File: rtl/chunked_adder_if.sv
// chunked_adder_if: operand/result handshake bundle
// master drives operands and takes results, slave is the adder
interface chunked_adder_if #(
  parameter int WIDTH = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, x, y, sub, out_ready,
    input  in_ready, out_valid, s, c_out, ovf
  );

  modport slave (
    input  in_valid, x, y, sub, out_ready,
    output in_ready, out_valid, s, c_out, ovf
  );
endinterface

// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle add/sub, CHUNK bits per clock
// carry is held in a register between chunks
module chunked_adder #(
  parameter int WIDTH = 5,
  parameter int CHUNK = 1
) (
  input logic            clk,
  input logic            rst,
  chunked_adder_if.slave io
);
  localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PW     = NCHUNK * CHUNK;
  localparam int LAST   = WIDTH - (NCHUNK - 1) * CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [PW-1:0]    a;
  logic [PW-1:0]    b;
  logic             carry;
  logic [IW-1:0]    idx;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] s_q;
  logic             c_q;
  logic             ovf_q;

  logic [WIDTH-1:0] yb;
  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic [CHUNK:0]   sum;
  logic             last;
  logic             c_msb;
  logic             c_in_msb;
  logic [PW-1:0]    merged;

  assign yb = io.sub ? ~io.y : io.y;
  assign ca = a[CHUNK-1:0];
  assign cb = b[CHUNK-1:0];
  assign sum = {1'b0, ca} + {1'b0, cb}
             + {{CHUNK{1'b0}}, carry};
  assign last = (idx == IW'(NCHUNK - 1));

  // padding above WIDTH is zero, so bit LAST of the
  // last chunk sum is the carry out of bit WIDTH-1
  assign c_msb = sum[LAST];
  assign c_in_msb = sum[LAST-1] ^ ca[LAST-1]
                  ^ cb[LAST-1];

  generate
    if (NCHUNK > 1) begin : g_work
      logic [PW-CHUNK-1:0] work;
      assign merged = {sum[CHUNK-1:0], work};
      // partial sums enter at the top and shift down
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          work <= '0;
        end else if (state == RUN) begin
          work <= merged[PW-1:CHUNK];
        end
      end
    end else begin : g_flat
      assign merged = sum[CHUNK-1:0];
    end
  endgenerate

  // sequencing, operand shifting and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a           <= '0;
      b           <= '0;
      carry       <= 1'b0;
      idx         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      s_q         <= '0;
      c_q         <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (io.in_valid) begin
            a          <= PW'(io.x);
            b          <= PW'(yb);
            carry      <= io.sub;
            idx        <= '0;
            in_ready_q <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          a     <= a >> CHUNK;
          b     <= b >> CHUNK;
          carry <= sum[CHUNK];
          idx   <= idx + IW'(1);
          if (last) begin
            s_q         <= merged[WIDTH-1:0];
            c_q         <= c_msb;
            ovf_q       <= c_in_msb ^ c_msb;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.s         = s_q;
  assign io.c_out     = c_q;
  assign io.ovf       = ovf_q;
endmodule

// File: tb/tb_chunked_adder.sv
// tb_chunked_adder: directed and randomised checks
// of chunked_adder against an arithmetic model
module tb_chunked_adder;
  localparam int NOPS = 500;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 5-bit group: CHUNK 1, 2, 5
  logic [1:0] sel5;
  logic       iv5;
  logic       or5;
  logic [4:0] x5;
  logic [4:0] y5;
  logic       sb5;

  chunked_adder_if #(.WIDTH(5)) if51();
  chunked_adder_if #(.WIDTH(5)) if52();
  chunked_adder_if #(.WIDTH(5)) if55();

  assign if51.x = x5;
  assign if52.x = x5;
  assign if55.x = x5;
  assign if51.y = y5;
  assign if52.y = y5;
  assign if55.y = y5;
  assign if51.sub = sb5;
  assign if52.sub = sb5;
  assign if55.sub = sb5;
  assign if51.in_valid = iv5 && sel5 == 2'd0;
  assign if52.in_valid = iv5 && sel5 == 2'd1;
  assign if55.in_valid = iv5 && sel5 == 2'd2;
  assign if51.out_ready = or5 && sel5 == 2'd0;
  assign if52.out_ready = or5 && sel5 == 2'd1;
  assign if55.out_ready = or5 && sel5 == 2'd2;

  chunked_adder #(.WIDTH(5), .CHUNK(1)) u51 (
    .clk(clk), .rst(rst), .io(if51));
  chunked_adder #(.WIDTH(5), .CHUNK(2)) u52 (
    .clk(clk), .rst(rst), .io(if52));
  chunked_adder #(.WIDTH(5), .CHUNK(5)) u55 (
    .clk(clk), .rst(rst), .io(if55));

  logic       ir5;
  logic       ov5;
  logic [4:0] s5;
  logic       c5;
  logic       o5;

  assign ir5 = sel5 == 2'd0 ? if51.in_ready :
               sel5 == 2'd1 ? if52.in_ready :
               if55.in_ready;
  assign ov5 = sel5 == 2'd0 ? if51.out_valid :
               sel5 == 2'd1 ? if52.out_valid :
               if55.out_valid;
  assign s5 = sel5 == 2'd0 ? if51.s :
              sel5 == 2'd1 ? if52.s : if55.s;
  assign c5 = sel5 == 2'd0 ? if51.c_out :
              sel5 == 2'd1 ? if52.c_out : if55.c_out;
  assign o5 = sel5 == 2'd0 ? if51.ovf :
              sel5 == 2'd1 ? if52.ovf : if55.ovf;

  // 8-bit group: CHUNK 1, 3, 8
  logic [1:0] sel8;
  logic       iv8;
  logic       or8;
  logic [7:0] x8;
  logic [7:0] y8;
  logic       sb8;

  chunked_adder_if #(.WIDTH(8)) if81();
  chunked_adder_if #(.WIDTH(8)) if83();
  chunked_adder_if #(.WIDTH(8)) if88();

  assign if81.x = x8;
  assign if83.x = x8;
  assign if88.x = x8;
  assign if81.y = y8;
  assign if83.y = y8;
  assign if88.y = y8;
  assign if81.sub = sb8;
  assign if83.sub = sb8;
  assign if88.sub = sb8;
  assign if81.in_valid = iv8 && sel8 == 2'd0;
  assign if83.in_valid = iv8 && sel8 == 2'd1;
  assign if88.in_valid = iv8 && sel8 == 2'd2;
  assign if81.out_ready = or8 && sel8 == 2'd0;
  assign if83.out_ready = or8 && sel8 == 2'd1;
  assign if88.out_ready = or8 && sel8 == 2'd2;

  chunked_adder #(.WIDTH(8), .CHUNK(1)) u81 (
    .clk(clk), .rst(rst), .io(if81));
  chunked_adder #(.WIDTH(8), .CHUNK(3)) u83 (
    .clk(clk), .rst(rst), .io(if83));
  chunked_adder #(.WIDTH(8), .CHUNK(8)) u88 (
    .clk(clk), .rst(rst), .io(if88));

  logic       ir8;
  logic       ov8;
  logic [7:0] s8;
  logic       c8;
  logic       o8;

  assign ir8 = sel8 == 2'd0 ? if81.in_ready :
               sel8 == 2'd1 ? if83.in_ready :
               if88.in_ready;
  assign ov8 = sel8 == 2'd0 ? if81.out_valid :
               sel8 == 2'd1 ? if83.out_valid :
               if88.out_valid;
  assign s8 = sel8 == 2'd0 ? if81.s :
              sel8 == 2'd1 ? if83.s : if88.s;
  assign c8 = sel8 == 2'd0 ? if81.c_out :
              sel8 == 2'd1 ? if83.c_out : if88.c_out;
  assign o8 = sel8 == 2'd0 ? if81.ovf :
              sel8 == 2'd1 ? if83.ovf : if88.ovf;

  // reference: unsigned and signed integer arithmetic
  function automatic logic [9:0] model(
    input int ux, input int uy, input logic sb);
    int m;
    int sx;
    int sy;
    int r;
    int sr;
    logic c;
    logic o;
    logic [7:0] s;
    m  = 256;
    sx = ux >= 128 ? ux - m : ux;
    sy = uy >= 128 ? uy - m : uy;
    if (!sb) begin
      r  = ux + uy;
      c  = r >= m;
      sr = sx + sy;
    end else begin
      r  = ux - uy + m;
      c  = ux >= uy;
      sr = sx - sy;
    end
    s = 8'(r % m);
    o = sr < -128 || sr > 127;
    return {s, c, o};
  endfunction

  task automatic do_op5(
    input logic [1:0] sel,
    input logic [4:0] x, input logic [4:0] y,
    input logic sb, input logic [4:0] es,
    input logic ec, input logic eo,
    input int elat, input string nm);
    int lat;
    @(negedge clk);
    sel5 = sel;
    x5 = x;
    y5 = y;
    sb5 = sb;
    iv5 = 1'b1;
    or5 = 1'b0;
    #1;
    checks++;
    if (ir5 !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready got %b want 1", nm, ir5);
    end
    @(posedge clk);
    #1;
    iv5 = 1'b0;
    x5 = 5'($urandom);
    y5 = 5'($urandom);
    sb5 = 1'($urandom);
    lat = 0;
    while (ov5 !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat != elat) begin
      errors++;
      $display("FAIL %s_lat got %0d want %0d",
               nm, lat, elat);
    end
    checks++;
    if ({s5, c5, o5} !== {es, ec, eo}) begin
      errors++;
      $display("FAIL %s got s=%0d c=%b v=%b want s=%0d c=%b v=%b",
               nm, s5, c5, o5, es, ec, eo);
    end
  endtask

  task automatic release5(input string nm);
    @(negedge clk);
    or5 = 1'b1;
    @(posedge clk);
    #1;
    or5 = 1'b0;
    checks++;
    if (ov5 !== 1'b0 || ir5 !== 1'b1) begin
      errors++;
      $display("FAIL %s_rel got ov=%b rdy=%b want 0 1",
               nm, ov5, ir5);
    end
  endtask

  task automatic test_reset();
    #2;
    rst = 1'b1;
    #1;
    sel5 = 2'd0;
    checks++;
    if (ir5 !== 1'b1 || ov5 !== 1'b0) begin
      errors++;
      $display("FAIL rst_hs got rdy=%b ov=%b want 1 0",
               ir5, ov5);
    end
    checks++;
    if ({s5, c5, o5} !== 7'd0) begin
      errors++;
      $display("FAIL rst_out got %b want 0",
               {s5, c5, o5});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    do_op5(2'd0, 5'd1, 5'd1, 1'b0,
           5'd2, 1'b0, 1'b0, 5, "add_1_1");
    release5("add_1_1");
    do_op5(2'd0, 5'd17, 5'd19, 1'b0,
           5'd4, 1'b1, 1'b1, 5, "add_17_19");
    release5("add_17_19");
    do_op5(2'd0, 5'd31, 5'd31, 1'b0,
           5'd30, 1'b1, 1'b0, 5, "add_31_31");
    release5("add_31_31");
  endtask

  task automatic test_sub();
    do_op5(2'd0, 5'd10, 5'd15, 1'b1,
           5'd27, 1'b0, 1'b0, 5, "sub_10_15");
    release5("sub_10_15");
    do_op5(2'd0, 5'd15, 5'd15, 1'b1,
           5'd0, 1'b1, 1'b0, 5, "sub_15_15");
    release5("sub_15_15");
    do_op5(2'd0, 5'd15, 5'd1, 1'b0,
           5'd16, 1'b0, 1'b1, 5, "add_15_1");
    release5("add_15_1");
  endtask

  task automatic test_chunks();
    do_op5(2'd1, 5'd1, 5'd31, 1'b0,
           5'd0, 1'b1, 1'b0, 3, "c2_1_31");
    release5("c2_1_31");
    do_op5(2'd1, 5'd16, 5'd16, 1'b0,
           5'd0, 1'b1, 1'b1, 3, "c2_16_16");
    release5("c2_16_16");
    do_op5(2'd2, 5'd1, 5'd31, 1'b0,
           5'd0, 1'b1, 1'b0, 1, "c5_1_31");
    release5("c5_1_31");
    do_op5(2'd2, 5'd3, 5'd5, 1'b1,
           5'd30, 1'b0, 1'b0, 1, "c5_3_5");
    release5("c5_3_5");
  endtask

  task automatic test_backpressure();
    logic bad;
    do_op5(2'd0, 5'd7, 5'd9, 1'b0,
           5'd16, 1'b0, 1'b1, 5, "bp");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      iv5 = (i == 1);
      x5 = 5'd3;
      y5 = 5'd4;
      #1;
      checks++;
      if (ov5 !== 1'b1 || ir5 !== 1'b0 ||
          {s5, c5, o5} !== {5'd16, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL bp_hold%0d got ov=%b rdy=%b s=%0d c=%b v=%b",
                 i, ov5, ir5, s5, c5, o5);
      end
    end
    @(negedge clk);
    iv5 = 1'b0;
    release5("bp");
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov5 !== 1'b0 || ir5 !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_noqueue got busy want idle");
    end
  endtask

  task automatic test_reset_midrun();
    logic bad;
    @(negedge clk);
    sel5 = 2'd0;
    x5 = 5'd9;
    y5 = 5'd9;
    sb5 = 1'b0;
    iv5 = 1'b1;
    @(posedge clk);
    #1;
    iv5 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (ov5 !== 1'b0 || ir5 !== 1'b1 ||
        {s5, c5, o5} !== 7'd0) begin
      errors++;
      $display("FAIL rst_mid got ov=%b rdy=%b s=%0d c=%b v=%b",
               ov5, ir5, s5, c5, o5);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov5 !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL rst_abort got out_valid want 0");
    end
    do_op5(2'd0, 5'd2, 5'd3, 1'b0,
           5'd5, 1'b0, 1'b0, 5, "rst_2_3");
    release5("rst_2_3");
  endtask

  task automatic test_back_to_back();
    logic [9:0] q[$];
    logic [9:0] e;
    int acc;
    int dlv;
    int cyc;
    logic bad;
    for (int k = 0; k < 3; k++) begin
      q.delete();
      acc = 0;
      dlv = 0;
      cyc = 0;
      @(negedge clk);
      sel8 = 2'(k);
      while ((acc < NOPS || q.size() > 0) &&
             cyc < 40000) begin
        @(negedge clk);
        cyc++;
        iv8 = acc < NOPS &&
              $urandom_range(0, 3) != 0;
        x8 = 8'($urandom);
        y8 = 8'($urandom);
        sb8 = 1'($urandom);
        or8 = $urandom_range(0, 2) != 0;
        #1;
        if (iv8 && ir8) begin
          q.push_back(model(int'(x8), int'(y8), sb8));
          acc++;
        end
        if (ov8 && or8) begin
          dlv++;
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL rnd%0d_extra got result want none",
                     k);
          end else begin
            e = q.pop_front();
            if ({s8, c8, o8} !== e) begin
              errors++;
              $display("FAIL rnd%0d got s=%0d c=%b v=%b want s=%0d c=%b v=%b",
                       k, s8, c8, o8, e[9:2], e[1], e[0]);
            end
          end
        end
      end
      iv8 = 1'b0;
      or8 = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (ov8 !== 1'b0) bad = 1'b1;
      end
      or8 = 1'b0;
      checks++;
      if (acc != NOPS || dlv != NOPS ||
          q.size() != 0 || bad) begin
        errors++;
        $display("FAIL rnd%0d_count got acc=%0d dlv=%0d want %0d",
                 k, acc, dlv, NOPS);
      end
    end
  endtask

  initial begin
    sel5 = 2'd0;
    iv5 = 1'b0;
    or5 = 1'b0;
    x5 = '0;
    y5 = '0;
    sb5 = 1'b0;
    sel8 = 2'd0;
    iv8 = 1'b0;
    or8 = 1'b0;
    x8 = '0;
    y8 = '0;
    sb8 = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_chunks();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
